// File: rtl/alu_fpga_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// alu_fpga_ctrl_pkg
// Purpose : shared types and helpers for the ALU board harness: the ALU
//           opcode enum, the operand width, seven-segment constants and the
//           active-low hex font used by every board display.
// Ports   : none (package).
// ---------------------------------------------------------------------------
package alu_fpga_ctrl_pkg;

   localparam int DATA_W = 32;

   typedef enum logic [3:0] {
      ALU_ADD = 4'd0,
      ALU_SUB = 4'd1,
      ALU_AND = 4'd2,
      ALU_OR  = 4'd3,
      ALU_XOR = 4'd4,
      ALU_SLL = 4'd5,
      ALU_SRL = 4'd6,
      ALU_SRA = 4'd7
   } aluop_t;

   // Segments are active-low, bit order {g,f,e,d,c,b,a}.
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0:    seg = 7'h40;
         4'h1:    seg = 7'h79;
         4'h2:    seg = 7'h24;
         4'h3:    seg = 7'h30;
         4'h4:    seg = 7'h19;
         4'h5:    seg = 7'h12;
         4'h6:    seg = 7'h02;
         4'h7:    seg = 7'h78;
         4'h8:    seg = 7'h00;
         4'h9:    seg = 7'h10;
         4'hA:    seg = 7'h08;
         4'hB:    seg = 7'h03;
         4'hC:    seg = 7'h46;
         4'hD:    seg = 7'h21;
         4'hE:    seg = 7'h06;
         default: seg = 7'h0E;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/alu_fpga_ctrl_if.sv
// ---------------------------------------------------------------------------
// alu_fpga_ctrl_if
// Purpose : board-side pins of the ALU harness.
// Signals : KEY  [3:0]        raw active-low buttons (board -> harness)
//           SW   [17:0]       slide switches        (board -> harness)
//           HEX  [NDIGITS*7]  active-low segments   (harness -> board)
//           LEDR [17:0]       status LEDs           (harness -> board)
// ---------------------------------------------------------------------------
interface alu_fpga_ctrl_if #(parameter int NDIGITS = 8);
   logic [3:0]           KEY;
   logic [17:0]          SW;
   logic [NDIGITS*7-1:0] HEX;
   logic [17:0]          LEDR;

   modport master (output KEY, SW, input HEX, LEDR);
   modport slave  (input KEY, SW, output HEX, LEDR);
endinterface

// File: rtl/alu_if.sv
// ---------------------------------------------------------------------------
// alu_if
// Purpose : connection bundle for the shared combinational ALU.
// Signals : a, b (operands), op (aluop_t) from the master;
//           o (result), n/v/z (negative, signed overflow, zero) from the ALU.
// ---------------------------------------------------------------------------
interface alu_if;
   import alu_fpga_ctrl_pkg::*;

   logic signed [DATA_W-1:0] a;
   logic signed [DATA_W-1:0] b;
   aluop_t                   op;
   logic signed [DATA_W-1:0] o;
   logic                     n;
   logic                     v;
   logic                     z;

   modport master (output a, b, op, input o, n, v, z);
   modport slave  (input a, b, op, output o, n, v, z);
endinterface

// File: rtl/alu_fpga_ctrl_alu.sv
// ---------------------------------------------------------------------------
// alu
// Purpose : shared combinational 32-bit ALU. Opcodes outside aluop_t return
//           zero with V cleared.
// Ports   : bus (alu_if.slave) - a, b, op in; o, n, v, z out.
// ---------------------------------------------------------------------------
module alu
   import alu_fpga_ctrl_pkg::*;
(
   alu_if.slave bus
);

   logic signed [DATA_W-1:0] sum;
   logic signed [DATA_W-1:0] dif;
   logic        [DATA_W-1:0] a_u;
   logic        [4:0]        sh;

   assign sum = bus.a + bus.b;
   assign dif = bus.a - bus.b;
   assign a_u = bus.a;
   assign sh  = bus.b[4:0];

   always_comb begin
      bus.o = '0;
      bus.v = 1'b0;
      case (bus.op)
         ALU_ADD: begin
            bus.o = sum;
            bus.v = (bus.a[DATA_W-1] == bus.b[DATA_W-1]) && (sum[DATA_W-1] != bus.a[DATA_W-1]);
         end
         ALU_SUB: begin
            bus.o = dif;
            bus.v = (bus.a[DATA_W-1] != bus.b[DATA_W-1]) && (dif[DATA_W-1] != bus.a[DATA_W-1]);
         end
         ALU_AND: bus.o = bus.a & bus.b;
         ALU_OR:  bus.o = bus.a | bus.b;
         ALU_XOR: bus.o = bus.a ^ bus.b;
         ALU_SLL: bus.o = bus.a << sh;
         ALU_SRL: bus.o = a_u >> sh;
         ALU_SRA: bus.o = bus.a >>> sh;
         default: bus.o = '0;
      endcase
   end

   assign bus.n = bus.o[DATA_W-1];
   assign bus.z = (bus.o == '0);

endmodule

// File: rtl/alu_fpga_ctrl_key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
// Purpose : one active-low push button: 2-flop synchroniser, stability
//           counter and a single-cycle press pulse on an accepted 1->0.
// Ports   : CLK, nRST (async active-low), raw (button pin),
//           press (1-cycle pulse per accepted press).
// After reset the key must first be seen released for DB_COUNT samples
// (armed) before a press can pulse, so a key held through reset is ignored.
// ---------------------------------------------------------------------------
module key_debounce #(
   parameter int DB_COUNT = 50000
) (
   input  logic CLK,
   input  logic nRST,
   input  logic raw,
   output logic press
);

   localparam int              CNT_W   = (DB_COUNT > 1) ? $clog2(DB_COUNT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_COUNT - 1);

   logic             sync_p0;
   logic             sync_p1;
   logic             prev_p2;
   logic [CNT_W-1:0] cnt;
   logic             level;
   logic             armed;
   logic             stable;

   assign stable = (sync_p1 == prev_p2) && (cnt == CNT_MAX);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         sync_p0 <= 1'b1;
         sync_p1 <= 1'b1;
         prev_p2 <= 1'b1;
         cnt     <= '0;
         level   <= 1'b1;
         armed   <= 1'b0;
         press   <= 1'b0;
      end else begin
         // p0/p1: synchroniser; p2: previous synced sample for change detect
         sync_p0 <= raw;
         sync_p1 <= sync_p0;
         prev_p2 <= sync_p1;
         press   <= 1'b0;
         if (sync_p1 != prev_p2) begin
            cnt <= '0;
         end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
         end
         if (stable) begin
            if (sync_p1 != level) begin
               level <= sync_p1;
               press <= ~sync_p1 & armed;
            end
            if (sync_p1) begin
               armed <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/alu_fpga_ctrl.sv
// ---------------------------------------------------------------------------
// alu_fpga_ctrl
// Purpose : board harness around the shared ALU. Debounced keys load
//           operands A/B from the switches, execute SW[3:0] on the ALU
//           (optionally accumulating into A), keep a result history and
//           show a selectable view on a seven-segment display.
// Ports   : CLK   system clock
//           nRST  async active-low reset
//           brd   board pins (alu_fpga_ctrl_if.slave):
//                 KEY[0] load A, KEY[1] load B, KEY[2] execute, KEY[3] next view
//                 SW[15:0] data, SW[16] sign, SW[3:0] opcode, SW[17] accumulate
//                 HEX digit i = nibble i of view (views: A, B, R, hist[0..])
//                 LEDR[2:0] {N,V,Z}, LEDR[7:4] view, LEDR[17] SW[17]
// ---------------------------------------------------------------------------
module alu_fpga_ctrl
   import alu_fpga_ctrl_pkg::*;
#(
   parameter int NDIGITS    = 8,
   parameter int DB_COUNT   = 50000,
   parameter int HIST_DEPTH = 4
) (
   input  logic            CLK,
   input  logic            nRST,
   alu_fpga_ctrl_if.slave  brd
);

   localparam int               NVIEWS    = 3 + HIST_DEPTH;
   localparam int               VIEW_W    = $clog2(NVIEWS);
   localparam int               CNT_W     = $clog2(HIST_DEPTH + 1);
   localparam logic [VIEW_W-1:0] VIEW_LAST = VIEW_W'(NVIEWS - 1);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (c == CNT_W'(HIST_DEPTH)) ? c : c + 1'b1;
   endfunction

   logic [17:0]              sw_p0;
   logic [17:0]              sw_p1;
   logic [3:0]               key_press;
   logic signed [DATA_W-1:0] ext;
   logic signed [DATA_W-1:0] a_q;
   logic signed [DATA_W-1:0] b_q;
   logic signed [DATA_W-1:0] r_q;
   logic [2:0]               flg_q;
   logic signed [DATA_W-1:0] hist_q [HIST_DEPTH];
   logic [CNT_W-1:0]         cnt_q;
   logic [VIEW_W-1:0]        view_q;
   logic signed [DATA_W-1:0] view_val;
   logic                     view_empty;
   logic [NDIGITS*7-1:0]     hex_next;
   logic [NDIGITS*7-1:0]     hex_q;
   logic [3:0]               view_led;

   alu_if alu_bus ();
   alu u_alu (.bus(alu_bus));

   for (genvar k = 0; k < 4; k++) begin : g_key
      key_debounce #(.DB_COUNT(DB_COUNT)) u_db (
         .CLK  (CLK),
         .nRST (nRST),
         .raw  (brd.KEY[k]),
         .press(key_press[k])
      );
   end

   assign ext        = {{16{sw_p1[16]}}, sw_p1[15:0]};
   assign alu_bus.a  = a_q;
   assign alu_bus.b  = b_q;
   assign alu_bus.op = aluop_t'(sw_p1[3:0]);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         sw_p0 <= '0;
         sw_p1 <= '0;
      end else begin
         // p0/p1: switch synchroniser
         sw_p0 <= brd.SW;
         sw_p1 <= sw_p0;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         a_q    <= '0;
         b_q    <= '0;
         r_q    <= '0;
         flg_q  <= '0;
         cnt_q  <= '0;
         view_q <= '0;
         for (int k = 0; k < HIST_DEPTH; k++) begin
            hist_q[k] <= '0;
         end
      end else begin
         if (key_press[0]) begin
            a_q <= ext;
         end
         if (key_press[1]) begin
            b_q <= ext;
         end
         if (key_press[3]) begin
            view_q <= (view_q == VIEW_LAST) ? '0 : view_q + 1'b1;
         end
         if (key_press[2]) begin
            r_q       <= alu_bus.o;
            flg_q     <= {alu_bus.n, alu_bus.v, alu_bus.z};
            hist_q[0] <= alu_bus.o;
            for (int k = 1; k < HIST_DEPTH; k++) begin
               hist_q[k] <= hist_q[k-1];
            end
            cnt_q <= sat_inc(cnt_q);
            // Accumulate wins over a same-cycle KEY0 load of A.
            if (sw_p1[17]) begin
               a_q <= alu_bus.o;
            end
         end
      end
   end

   always_comb begin
      view_val   = a_q;
      view_empty = 1'b0;
      if (view_q == VIEW_W'(1)) begin
         view_val = b_q;
      end else if (view_q == VIEW_W'(2)) begin
         view_val = r_q;
      end
      for (int k = 0; k < HIST_DEPTH; k++) begin
         if (view_q == VIEW_W'(3 + k)) begin
            view_val   = hist_q[k];
            view_empty = (CNT_W'(k) >= cnt_q);
         end
      end
   end

   always_comb begin
      hex_next = '0;
      for (int i = 0; i < NDIGITS; i++) begin
         if (i >= 8) begin
            hex_next[i*7 +: 7] = SEG_BLANK;
         end else if (view_empty) begin
            hex_next[i*7 +: 7] = SEG_DASH;
         end else begin
            hex_next[i*7 +: 7] = hex_to_seg(view_val[(i % 8)*4 +: 4]);
         end
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         hex_q <= {NDIGITS{SEG_BLANK}};
      end else begin
         // display register: one cycle behind the view/value it shows
         hex_q <= hex_next;
      end
   end

   assign view_led = 4'(view_q);
   assign brd.HEX  = hex_q;
   assign brd.LEDR = {sw_p1[17], 9'b0, view_led, 1'b0, flg_q};

endmodule

// File: tb/tb_alu_fpga_ctrl.sv
module tb_alu_fpga_ctrl;

   localparam int NDIGITS    = 8;
   localparam int DB_COUNT   = 4;
   localparam int HIST_DEPTH = 4;
   localparam int HOLD       = DB_COUNT + 8;

   logic CLK  = 1'b0;
   logic nRST = 1'b0;

   always #5 CLK = ~CLK;

   alu_fpga_ctrl_if #(.NDIGITS(NDIGITS)) brd ();

   alu_fpga_ctrl #(
      .NDIGITS   (NDIGITS),
      .DB_COUNT  (DB_COUNT),
      .HIST_DEPTH(HIST_DEPTH)
   ) dut (
      .CLK (CLK),
      .nRST(nRST),
      .brd (brd)
   );

   int checks = 0;
   int errors = 0;

   logic [6:0] font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   typedef struct {
      logic [17:0] a_sw;
      logic [17:0] b_sw;
      logic [3:0]  op;
      logic [31:0] r;
      logic [2:0]  flg;
   } vec_t;

   typedef struct {
      logic [31:0] r;
      logic [2:0]  flg;
   } exp_t;

   vec_t vecs [9];
   exp_t sb [$];

   function automatic logic [NDIGITS*7-1:0] exp_hex(input logic [31:0] v);
      logic [NDIGITS*7-1:0] e;
      for (int i = 0; i < NDIGITS; i++) begin
         e[i*7 +: 7] = font[v[i*4 +: 4]];
      end
      return e;
   endfunction

   function automatic logic [NDIGITS*7-1:0] exp_dash();
      return {NDIGITS{7'b0111111}};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic settle(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic press(input logic [3:0] mask, input logic [17:0] sw);
      brd.SW  = sw;
      brd.KEY = ~mask;
      settle(HOLD);
      brd.KEY = 4'hF;
      settle(HOLD);
   endtask

   task automatic do_reset();
      nRST = 1'b0;
      settle(2);
      nRST = 1'b1;
      settle(HOLD);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t         e;
      logic [31:0]  acc_view [7];
      logic         acc_dash [7];

      vecs[0] = '{18'h1FFFE, 18'h00001, 4'd0, 32'hFFFF_FFFF, 3'b100};
      vecs[1] = '{18'h00005, 18'h00005, 4'd1, 32'h0000_0000, 3'b001};
      vecs[2] = '{18'h0F0F0, 18'h0FF00, 4'd2, 32'h0000_F000, 3'b000};
      vecs[3] = '{18'h0F0F0, 18'h0FF00, 4'd3, 32'h0000_FFF0, 3'b000};
      vecs[4] = '{18'h0F0F0, 18'h0FF00, 4'd4, 32'h0000_0FF0, 3'b000};
      vecs[5] = '{18'h00001, 18'h0001F, 4'd5, 32'h8000_0000, 3'b100};
      vecs[6] = '{18'h18000, 18'h00004, 4'd6, 32'h0FFF_F800, 3'b000};
      vecs[7] = '{18'h18000, 18'h00004, 4'd7, 32'hFFFF_F800, 3'b100};
      vecs[8] = '{18'h00003, 18'h00005, 4'd1, 32'hFFFF_FFFE, 3'b100};

      // views 1..6 then 0 after three accumulating ADDs from A=B=1
      acc_view = '{32'd1, 32'd4, 32'd4, 32'd3, 32'd2, 32'd0, 32'd4};
      acc_dash = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

      brd.KEY = 4'hF;
      brd.SW  = '0;
      nRST    = 1'b0;
      settle(3);
      chk("reset_hex", 64'(brd.HEX), 64'({NDIGITS{7'h7F}}));
      chk("reset_ledr", 64'(brd.LEDR), 64'd0);
      nRST = 1'b1;
      settle(2);
      chk("post_reset_hex", 64'(brd.HEX), 64'(exp_hex(32'd0)));
      chk("post_reset_ledr", 64'(brd.LEDR), 64'd0);
      settle(HOLD);

      // select view 2 (R) for the vector table
      press(4'b1000, 18'h0);
      press(4'b1000, 18'h0);
      chk("view2_led", 64'(brd.LEDR[7:4]), 64'd2);
      chk("view2_hex", 64'(brd.HEX), 64'(exp_hex(32'd0)));

      for (int i = 0; i < 9; i++) begin
         press(4'b0001, vecs[i].a_sw);
         press(4'b0010, vecs[i].b_sw);
         sb.push_back('{vecs[i].r, vecs[i].flg});
         press(4'b0100, {14'b0, vecs[i].op});
         e = sb.pop_front();
         chk($sformatf("vec%0d_r", i), 64'(brd.HEX), 64'(exp_hex(e.r)));
         chk($sformatf("vec%0d_flg", i), 64'(brd.LEDR[2:0]), 64'(e.flg));
      end

      // bounced execute must register once
      do_reset();
      press(4'b1000, 18'h0);
      press(4'b1000, 18'h0);
      press(4'b1000, 18'h0);
      chk("bounce_empty_hist0", 64'(brd.HEX), 64'(exp_dash()));
      press(4'b0001, 18'h00002);
      press(4'b0010, 18'h00003);
      brd.SW = 18'h0;
      for (int j = 0; j < 5; j++) begin
         brd.KEY[2] = 1'b0;
         settle(3);
         brd.KEY[2] = 1'b1;
         settle(1);
      end
      brd.KEY[2] = 1'b0;
      settle(HOLD);
      brd.KEY[2] = 1'b1;
      settle(HOLD);
      chk("bounce_hist0", 64'(brd.HEX), 64'(exp_hex(32'd5)));
      press(4'b1000, 18'h0);
      chk("bounce_hist1_dash", 64'(brd.HEX), 64'(exp_dash()));

      // accumulate mode and view wrap
      do_reset();
      press(4'b0001, 18'h00001);
      press(4'b0010, 18'h00001);
      for (int j = 0; j < 3; j++) begin
         press(4'b0100, 18'h20000);
      end
      chk("acc_a", 64'(brd.HEX), 64'(exp_hex(32'd4)));
      chk("acc_led17", 64'(brd.LEDR[17]), 64'd1);
      chk("acc_flg", 64'(brd.LEDR[2:0]), 64'd0);
      for (int j = 0; j < 7; j++) begin
         press(4'b1000, 18'h20000);
         chk($sformatf("wrap%0d_led", j), 64'(brd.LEDR[7:4]), 64'((j + 1) % 7));
         chk($sformatf("wrap%0d_hex", j), 64'(brd.HEX),
             acc_dash[j] ? 64'(exp_dash()) : 64'(exp_hex(acc_view[j])));
      end

      // same-cycle load A + accumulate execute: result wins, ext=0 ignored
      press(4'b0101, 18'h20000);
      chk("simul_a", 64'(brd.HEX), 64'(exp_hex(32'd5)));
      press(4'b1000, 18'h20000);
      press(4'b1000, 18'h20000);
      press(4'b1000, 18'h20000);
      chk("simul_hist0", 64'(brd.HEX), 64'(exp_hex(32'd5)));
      press(4'b1000, 18'h20000);
      chk("simul_hist1", 64'(brd.HEX), 64'(exp_hex(32'd4)));

      // reset while execute key held: no execute until re-press (0+0 sets Z)
      brd.SW     = 18'h0;
      brd.KEY[2] = 1'b0;
      settle(2);
      nRST = 1'b0;
      settle(2);
      nRST = 1'b1;
      settle(HOLD + 2);
      chk("rst_held_flg", 64'(brd.LEDR[2:0]), 64'd0);
      brd.KEY[2] = 1'b1;
      settle(HOLD);
      chk("rst_release_flg", 64'(brd.LEDR[2:0]), 64'd0);
      press(4'b0100, 18'h0);
      chk("rst_repress_flg", 64'(brd.LEDR[2:0]), 64'b001);
      chk("rst_repress_a", 64'(brd.HEX), 64'(exp_hex(32'd0)));
      chk("sb_empty", 64'(sb.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
